// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
// Sequencer that drives the alu01 operand/op interface on behalf of the
// calculator control path. It accepts a command (op code plus two operands)
// over a valid/ready handshake and registers x/y/op into the ALU. After
// SETTLE_CYCLES clock edges it captures the ALU result and zero flag. It then
// returns them, together with a derived signed-overflow bit, over a
// valid/ready response channel.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op                0=ADD 1=SUB 2=AND 3=OR, 4..7 illegal
//   cmd_a, cmd_b          operands
//   alu_x, alu_y, alu_op  registered ALU drive (ADD=010 SUB=110 AND=000 OR=001)
//   alu_r, alu_zero       ALU result and zero flag
//   rsp_valid/rsp_ready   response handshake
//   rsp_result, rsp_zero  captured ALU outputs
//   rsp_ovf               signed overflow for ADD/SUB, 0 for AND/OR
//   rsp_err               illegal op code
//   ops_done              count of delivered non-error responses (wraps)

module alu_cmd_issuer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] settle_cnt;
    logic       op_is_add;
    logic       op_is_sub;

    logic       accept_legal;
    logic       accept_illegal;
    logic       count_down;
    logic       capture;
    logic       rsp_done;
    logic       ovf_calc;

    // Map the calculator op code onto the alu01 control encoding.
    function automatic logic [2:0] encode_op(input logic [1:0] op);
        case (op)
            2'd0:    encode_op = 3'b010;
            2'd1:    encode_op = 3'b110;
            2'd2:    encode_op = 3'b000;
            default: encode_op = 3'b001;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Overflow is judged from the operands actually driven into the ALU and
    // the result it returns, so it matches what was captured.
    always_comb begin
        ovf_calc = 1'b0;
        if (op_is_add) begin
            ovf_calc = (alu_x[WIDTH-1] == alu_y[WIDTH-1]) &&
                       (alu_r[WIDTH-1] != alu_x[WIDTH-1]);
        end else if (op_is_sub) begin
            ovf_calc = (alu_x[WIDTH-1] != alu_y[WIDTH-1]) &&
                       (alu_r[WIDTH-1] != alu_x[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Illegal ops skip the ALU entirely and respond straight away.
    always_comb begin
        next_state     = state;
        accept_legal   = 1'b0;
        accept_illegal = 1'b0;
        count_down     = 1'b0;
        capture        = 1'b0;
        rsp_done       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op[2]) begin
                        accept_illegal = 1'b1;
                        next_state     = RESP;
                    end else begin
                        accept_legal = 1'b1;
                        next_state   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (settle_cnt == 4'd0) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end else begin
                    count_down = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_x      <= '0;
            alu_y      <= '0;
            alu_op     <= 3'b000;
            settle_cnt <= 4'd0;
            op_is_add  <= 1'b0;
            op_is_sub  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
            ops_done   <= '0;
        end else begin
            if (accept_legal) begin
                alu_x      <= cmd_a;
                alu_y      <= cmd_b;
                alu_op     <= encode_op(cmd_op[1:0]);
                settle_cnt <= SETTLE_LOAD;
                op_is_add  <= (cmd_op[1:0] == 2'd0);
                op_is_sub  <= (cmd_op[1:0] == 2'd1);
            end
            if (accept_illegal) begin
                rsp_result <= '0;
                rsp_zero   <= 1'b0;
                rsp_ovf    <= 1'b0;
                rsp_err    <= 1'b1;
            end
            if (count_down) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (capture) begin
                rsp_result <= alu_r;
                rsp_zero   <= alu_zero;
                rsp_ovf    <= ovf_calc;
                rsp_err    <= 1'b0;
            end
            if (rsp_done && !rsp_err) begin
                ops_done <= ops_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer
// Self-checking bench for alu_cmd_issuer. Two instances share clk/rst_n:
// index 0 uses SETTLE_CYCLES=1, index 1 uses SETTLE_CYCLES=4. Each instance
// has a behavioural alu01 model hanging off its alu_* outputs. Expected
// responses are pushed to a scoreboard queue when a command is issued. They
// are popped and compared when the response appears.

module tb_alu_cmd_issuer;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic         ovf;
        logic         err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic         cmd_valid  [2];
    logic         cmd_ready  [2];
    logic [2:0]   cmd_op     [2];
    logic [W-1:0] cmd_a      [2];
    logic [W-1:0] cmd_b      [2];
    logic [W-1:0] alu_x      [2];
    logic [W-1:0] alu_y      [2];
    logic [2:0]   alu_op     [2];
    logic [W-1:0] alu_r      [2];
    logic         alu_zero   [2];
    logic         rsp_valid  [2];
    logic         rsp_ready  [2];
    logic [W-1:0] rsp_result [2];
    logic         rsp_zero   [2];
    logic         rsp_ovf    [2];
    logic         rsp_err    [2];
    logic [15:0]  ops_done   [2];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural alu01: combinational on the registered drive.
    function automatic logic [W-1:0] alu_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic [2:0] op);
        case (op)
            3'b010:  alu_model = x + y;
            3'b110:  alu_model = x - y;
            3'b000:  alu_model = x & y;
            3'b001:  alu_model = x | y;
            default: alu_model = '0;
        endcase
    endfunction

    assign alu_r[0]    = alu_model(alu_x[0], alu_y[0], alu_op[0]);
    assign alu_zero[0] = (alu_r[0] == '0);
    assign alu_r[1]    = alu_model(alu_x[1], alu_y[1], alu_op[1]);
    assign alu_zero[1] = (alu_r[1] == '0);

    // Expected response from the command as the calculator sees it.
    function automatic exp_t make_exp(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] r;
        e = '0;
        r = '0;
        case (op)
            3'd0: begin
                r     = a + b;
                e.ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin
                r     = a - b;
                e.ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            default: e.err = 1'b1;
        endcase
        e.result = r;
        e.zero   = !e.err && (r == '0);
        return e;
    endfunction

    alu_cmd_issuer #(.WIDTH(W), .SETTLE_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
        .alu_x(alu_x[0]), .alu_y(alu_y[0]), .alu_op(alu_op[0]),
        .alu_r(alu_r[0]), .alu_zero(alu_zero[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_result(rsp_result[0]), .rsp_zero(rsp_zero[0]), .rsp_ovf(rsp_ovf[0]),
        .rsp_err(rsp_err[0]), .ops_done(ops_done[0])
    );

    alu_cmd_issuer #(.WIDTH(W), .SETTLE_CYCLES(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
        .alu_x(alu_x[1]), .alu_y(alu_y[1]), .alu_op(alu_op[1]),
        .alu_r(alu_r[1]), .alu_zero(alu_zero[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_result(rsp_result[1]), .rsp_zero(rsp_zero[1]), .rsp_ovf(rsp_ovf[1]),
        .rsp_err(rsp_err[1]), .ops_done(ops_done[1])
    );

    // Present a command at a falling edge and hold it until accepted.
    // Returns #1 after the accepting edge with cmd_valid dropped.
    task automatic issue(input int d, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output bit ok);
        @(negedge clk);
        cmd_op[d]    = op;
        cmd_a[d]     = a;
        cmd_b[d]     = b;
        cmd_valid[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        cmd_valid[d] = 1'b0;
    endtask

    // Count falling edges until rsp_valid is seen.
    task automatic wait_rsp(input int d, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid[d]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at a falling edge with rsp_valid high; completes the handshake.
    task automatic ack(input int d);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({alu_x[d], alu_y[d], alu_op[d], rsp_valid[d], rsp_result[d], rsp_zero[d],
                 rsp_ovf[d], rsp_err[d], ops_done[d]} !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs dut%0d: x=%h y=%h op=%b v=%b r=%h z=%b o=%b e=%b n=%0d, all required 0",
                         d, alu_x[d], alu_y[d], alu_op[d], rsp_valid[d], rsp_result[d],
                         rsp_zero[d], rsp_ovf[d], rsp_err[d], ops_done[d]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // rsp_ready while idle must do nothing.
        rsp_ready[0] = 1'b1;
        repeat (3) @(negedge clk);
        rsp_ready[0] = 1'b0;
        n_checks++;
        if ({cmd_ready[0], cmd_ready[1], rsp_valid[0], ops_done[0]} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
            n_fail++;
            $display("[TB] FAIL after_reset: ready0=%b ready1=%b valid0=%b ops0=%0d, required 1 1 0 0",
                     cmd_ready[0], cmd_ready[1], rsp_valid[0], ops_done[0]);
        end
    endtask

    task automatic test_legal_ops();
        logic [2:0]   ops  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd0, 3'd1};
        logic [W-1:0] as   [8] = '{32'h1, 32'h2, 32'h1, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                                   32'h7FFF_FFFF, 32'h0};
        logic [W-1:0] bs   [8] = '{32'h10, 32'h2, 32'h1, 32'h10, 32'h1, 32'h1,
                                   32'hFFFF_FFFF, 32'h8000_0000};
        logic [2:0]   encs [8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b010, 3'b110,
                                   3'b010, 3'b110};
        exp_t got;
        bit   ok;
        int   n;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(make_exp(ops[i], as[i], bs[i]));
            issue(0, ops[i], as[i], bs[i], ok);
            n_checks++;
            if (!ok || alu_op[0] !== encs[i] || alu_x[0] !== as[i] || alu_y[0] !== bs[i]) begin
                n_fail++;
                $display("[TB] FAIL issue_%0d: accepted=%b op=%b x=%h y=%h, required 1 %b %h %h",
                         i, ok, alu_op[0], alu_x[0], alu_y[0], encs[i], as[i], bs[i]);
            end
            wait_rsp(0, n, ok);
            n_checks++;
            if (!ok || n != 2) begin
                n_fail++;
                $display("[TB] FAIL latency_%0d: seen=%b edges=%0d, required 1 2", i, ok, n);
            end
            got = sb.pop_front();
            n_checks++;
            if ({rsp_result[0], rsp_zero[0], rsp_ovf[0], rsp_err[0]} !== got) begin
                n_fail++;
                $display("[TB] FAIL rsp_%0d: r=%h z=%b o=%b e=%b, required r=%h z=%b o=%b e=%b",
                         i, rsp_result[0], rsp_zero[0], rsp_ovf[0], rsp_err[0],
                         got.result, got.zero, got.ovf, got.err);
            end
            ack(0);
            n_checks++;
            if (ops_done[0] !== 16'(i + 1) || rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL handshake_%0d: ops=%0d valid=%b ready=%b, required %0d 0 1",
                         i, ops_done[0], rsp_valid[0], cmd_ready[0], i + 1);
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] ops [3] = '{3'd5, 3'd4, 3'd7};
        exp_t got;
        bit   ok;
        int   n;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(make_exp(ops[i], 32'hDEAD_0000, 32'h0000_BEEF));
            issue(0, ops[i], 32'hDEAD_0000, 32'h0000_BEEF, ok);
            wait_rsp(0, n, ok);
            n_checks++;
            if (!ok || n != 1) begin
                n_fail++;
                $display("[TB] FAIL illegal_latency_%0d: seen=%b edges=%0d, required 1 1", i, ok, n);
            end
            got = sb.pop_front();
            n_checks++;
            if ({rsp_result[0], rsp_zero[0], rsp_ovf[0], rsp_err[0]} !== got) begin
                n_fail++;
                $display("[TB] FAIL illegal_rsp_%0d: r=%h z=%b o=%b e=%b, required r=%h z=%b o=%b e=%b",
                         i, rsp_result[0], rsp_zero[0], rsp_ovf[0], rsp_err[0],
                         got.result, got.zero, got.ovf, got.err);
            end
            n_checks++;
            if (alu_x[0] !== 32'h0 || alu_y[0] !== 32'h8000_0000 || alu_op[0] !== 3'b110) begin
                n_fail++;
                $display("[TB] FAIL illegal_alu_hold_%0d: x=%h y=%h op=%b, required 0 80000000 110",
                         i, alu_x[0], alu_y[0], alu_op[0]);
            end
            ack(0);
            n_checks++;
            if (ops_done[0] !== 16'd8 || cmd_ready[0] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL illegal_count_%0d: ops=%0d ready=%b, required 8 1",
                         i, ops_done[0], cmd_ready[0]);
            end
        end
    endtask

    task automatic test_settle_stall();
        exp_t got;
        bit   ok;
        int   n;
        sb.push_back(make_exp(3'd0, 32'h5, 32'h7));
        issue(1, 3'd0, 32'h5, 32'h7, ok);
        // Second command offered while the first is still in flight.
        cmd_op[1]    = 3'd3;
        cmd_a[1]     = 32'hF0;
        cmd_b[1]     = 32'h0F;
        cmd_valid[1] = 1'b1;
        wait_rsp(1, n, ok);
        n_checks++;
        if (!ok || n != 5) begin
            n_fail++;
            $display("[TB] FAIL settle4_latency: seen=%b edges=%0d, required 1 5", ok, n);
        end
        got = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({rsp_result[1], rsp_zero[1], rsp_ovf[1], rsp_err[1]} !== got ||
                rsp_valid[1] !== 1'b1 || cmd_ready[1] !== 1'b0 || alu_x[1] !== 32'h5) begin
                n_fail++;
                $display("[TB] FAIL stall_%0d: r=%h z=%b o=%b e=%b v=%b rdy=%b x=%h, required r=%h z=%b o=%b e=%b v=1 rdy=0 x=5",
                         k, rsp_result[1], rsp_zero[1], rsp_ovf[1], rsp_err[1], rsp_valid[1],
                         cmd_ready[1], alu_x[1], got.result, got.zero, got.ovf, got.err);
            end
            @(negedge clk);
        end
        ack(1);
        n_checks++;
        if (cmd_ready[1] !== 1'b1 || alu_x[1] !== 32'h5 || rsp_valid[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL turnaround: ready=%b x=%h valid=%b, required 1 5 0",
                     cmd_ready[1], alu_x[1], rsp_valid[1]);
        end
        sb.push_back(make_exp(3'd3, 32'hF0, 32'h0F));
        @(posedge clk);
        #1;
        cmd_valid[1] = 1'b0;
        n_checks++;
        if (alu_x[1] !== 32'hF0 || alu_y[1] !== 32'h0F || alu_op[1] !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL second_accept: x=%h y=%h op=%b, required f0 0f 001",
                     alu_x[1], alu_y[1], alu_op[1]);
        end
        wait_rsp(1, n, ok);
        got = sb.pop_front();
        n_checks++;
        if (!ok || n != 5 || {rsp_result[1], rsp_zero[1], rsp_ovf[1], rsp_err[1]} !== got) begin
            n_fail++;
            $display("[TB] FAIL second_rsp: seen=%b edges=%0d r=%h z=%b o=%b e=%b, required 1 5 r=%h z=%b o=%b e=%b",
                     ok, n, rsp_result[1], rsp_zero[1], rsp_ovf[1], rsp_err[1],
                     got.result, got.zero, got.ovf, got.err);
        end
        ack(1);
        n_checks++;
        if (ops_done[1] !== 16'd2) begin
            n_fail++;
            $display("[TB] FAIL settle4_count: ops=%0d, required 2", ops_done[1]);
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bit stale;
        issue(1, 3'd0, 32'h3, 32'h4, ok);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({alu_x[d], alu_y[d], alu_op[d], rsp_valid[d], rsp_result[d], rsp_zero[d],
                 rsp_ovf[d], rsp_err[d], ops_done[d]} !== '0) begin
                n_fail++;
                $display("[TB] FAIL midop_reset dut%0d: x=%h y=%h op=%b v=%b r=%h z=%b o=%b e=%b n=%0d, all required 0",
                         d, alu_x[d], alu_y[d], alu_op[d], rsp_valid[d], rsp_result[d],
                         rsp_zero[d], rsp_ovf[d], rsp_err[d], ops_done[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0 || cmd_ready[1] !== 1'b1) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_fail++;
            $display("[TB] FAIL midop_recover: stale response or ready low after reset (valid=%b ready=%b), required valid=0 ready=1",
                     rsp_valid[1], cmd_ready[1]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_op[d]    = 3'd0;
            cmd_a[d]     = '0;
            cmd_b[d]     = '0;
            rsp_ready[d] = 1'b0;
        end
        test_reset();
        test_legal_ops();
        test_illegal();
        test_settle_stall();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
